// File: rtl/issue_queue_mw_pkg.sv
// Public_Info: shared instruction record type and default issue queue geometry.
package Public_Info;

   // Packed decoded instruction record carried through the issue queue.
   typedef struct packed {
      logic [63:0]  pc;
      logic [31:0]  instr;
      logic [159:0] uop;
   } PC_set;

   localparam int IQ_DEPTH = 16;
   localparam int IQ_IN_W  = 2;
   localparam int IQ_OUT_W = 2;

endpackage

// File: rtl/issue_queue_mw_ptr_wrap.sv
// iq_ptr_wrap: circular-buffer pointer adder, wraps at DEPTH (need not be a power of two).
module iq_ptr_wrap #(
   parameter int DEPTH = 16,
   parameter int PW    = $clog2(DEPTH),
   parameter int IW    = PW + 1
) (
   input  logic [PW-1:0] i_ptr,
   input  logic [IW-1:0] i_inc,
   output logic [PW-1:0] o_ptr
);
   localparam logic [IW-1:0] W_DEPTH = IW'(DEPTH);

   logic [IW-1:0] w_sum;
   logic [IW-1:0] w_wrapped;

   assign w_sum     = {1'b0, i_ptr} + i_inc;
   assign w_wrapped = w_sum - W_DEPTH;
   assign o_ptr     = (w_sum >= W_DEPTH) ? w_wrapped[PW-1:0] : w_sum[PW-1:0];

endmodule

// File: rtl/issue_queue_mw.sv
// issue_queue_mw: multi-lane in-order issue buffer; define IQ_STATS_EN to build the push/full statistics counters.
module issue_queue_mw
   import Public_Info::*;
#(
   parameter int DATA_W    = $bits(PC_set),
   parameter int DEPTH     = IQ_DEPTH,
   parameter int IN_W      = IQ_IN_W,
   parameter int OUT_W     = IQ_OUT_W,
   parameter int AF_THRESH = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [IN_W-1:0]            in_valid,
   input  logic [IN_W*DATA_W-1:0]     in_data,
   output logic                       in_ready,
   output logic [OUT_W-1:0]           out_valid,
   output logic [OUT_W*DATA_W-1:0]    out_data,
   input  logic [$clog2(OUT_W+1)-1:0] out_pop,
   input  logic                       flush,
   input  logic                       stall,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic [31:0]                stat_push_cnt,
   output logic [31:0]                stat_full_cycles
);
   localparam int PW = $clog2(DEPTH);
   localparam int IW = PW + 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] AF_LVL = CW'(DEPTH - AF_THRESH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_count;
   logic              r_af;

   logic              w_gap;
   logic [IW-1:0]     w_run;
   logic [IW-1:0]     w_push_n;
   logic [IW-1:0]     w_pop_n;
   logic [CW-1:0]     w_cnt_nxt;
   logic [PW-1:0]     w_head_nxt;
   logic [PW-1:0]     w_tail_nxt;
   logic [PW-1:0]     w_wr_ptr [IN_W];
   logic [PW-1:0]     w_rd_ptr [OUT_W];

   // Ready depends only on registered occupancy so fetch never sees a pop-dependent path.
   assign in_ready    = (CW'(DEPTH) - r_count) >= CW'(IN_W);
   assign count       = r_count;
   assign almost_full = r_af;

   // Accepted lanes are the contiguous valid prefix from lane 0; flush discards the group.
   always_comb begin
      w_gap = 1'b0;
      w_run = '0;
      for (int i = 0; i < IN_W; i++) begin
         w_gap = w_gap | ~in_valid[i];
         w_run = w_run + {{(IW-1){1'b0}}, ~w_gap};
      end
      w_push_n  = (in_ready && !flush) ? w_run : '0;
      w_pop_n   = stall ? '0 : IW'(out_pop);
      w_cnt_nxt = r_count + CW'(w_push_n) - CW'(w_pop_n);
   end

   iq_ptr_wrap #(.DEPTH(DEPTH)) u_head_nxt (.i_ptr(r_head), .i_inc(w_push_n), .o_ptr(w_head_nxt));
   iq_ptr_wrap #(.DEPTH(DEPTH)) u_tail_nxt (.i_ptr(r_tail), .i_inc(w_pop_n),  .o_ptr(w_tail_nxt));

   for (genvar g = 0; g < IN_W; g++) begin : g_wr
      iq_ptr_wrap #(.DEPTH(DEPTH)) u_wr (.i_ptr(r_head), .i_inc(IW'(g)), .o_ptr(w_wr_ptr[g]));
   end

   for (genvar g = 0; g < OUT_W; g++) begin : g_rd
      iq_ptr_wrap #(.DEPTH(DEPTH)) u_rd (.i_ptr(r_tail), .i_inc(IW'(g)), .o_ptr(w_rd_ptr[g]));
      assign out_valid[g]                 = r_count > CW'(g);
      assign out_data[g*DATA_W +: DATA_W] = r_mem[w_rd_ptr[g]];
   end

   // Pointer, occupancy and almost-full state; reset and flush both empty the queue in one cycle.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_af    <= 1'b0;
      end else begin
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_cnt_nxt;
         r_af    <= w_cnt_nxt >= AF_LVL;
      end
   end

   // Record storage is left unreset; only slots covered by count are ever presented as valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_W; i++)
         if (IW'(i) < w_push_n) r_mem[w_wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
   end

   a_valid_prefix: assert property (@(posedge clk) disable iff (!rstn)
      (in_valid & (in_valid + IN_W'(1))) == '0);

   a_pop_legal: assert property (@(posedge clk) disable iff (!rstn)
      (CW'(out_pop) <= r_count) && (CW'(out_pop) <= CW'(OUT_W)));

`ifdef IQ_STATS_EN
   logic [31:0] r_stat_push;
   logic [31:0] r_stat_full;

   // Lifetime counters survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_stat_push <= '0;
         r_stat_full <= '0;
      end else begin
         r_stat_push <= r_stat_push + 32'(w_push_n);
         if (!in_ready && in_valid[0]) r_stat_full <= r_stat_full + 32'd1;
      end
   end

   assign stat_push_cnt    = r_stat_push;
   assign stat_full_cycles = r_stat_full;
`else
   assign stat_push_cnt    = 32'd0;
   assign stat_full_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_issue_queue_mw.sv
// tb_issue_queue_mw: directed self-checking bench for issue_queue_mw at default geometry.
module tb_issue_queue_mw;
   localparam int DW = 256;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [1:0]      in_valid = '0;
   logic [2*DW-1:0] in_data = '0;
   logic            in_ready;
   logic [1:0]      out_valid;
   logic [2*DW-1:0] out_data;
   logic [1:0]      out_pop = '0;
   logic            flush = 1'b0;
   logic            stall = 1'b0;
   logic [4:0]      count;
   logic            almost_full;
   logic [31:0]     stat_push_cnt;
   logic [31:0]     stat_full_cycles;

   int checks = 0;
   int errors = 0;
   int exp_push = 0;
   int exp_full = 0;

   always #5 clk = ~clk;

   issue_queue_mw dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_pop(out_pop), .flush(flush), .stall(stall),
      .count(count), .almost_full(almost_full), .stat_push_cnt(stat_push_cnt),
      .stat_full_cycles(stat_full_cycles)
   );

   function automatic logic [DW-1:0] rec(input int k);
      rec = {32'(k), 192'd0, 32'hC0DE0000 | 32'(k)};
   endfunction

   task automatic step(input logic [1:0] v, input int a, input int b, input logic [1:0] pop,
                       input logic st, input logic fl);
      in_valid = v;
      in_data  = {rec(b), rec(a)};
      out_pop  = pop;
      stall    = st;
      flush    = fl;
      @(posedge clk);
      #1;
      in_valid = '0;
      out_pop  = '0;
      stall    = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      in_valid = 2'b11;
      in_data = {rec(9), rec(8)};
      repeat (2) @(posedge clk);
      #1;
      in_valid = '0;
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b exp 00", out_valid); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (stat_push_cnt !== 32'd0 || stat_full_cycles !== 32'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_push_cnt, stat_full_cycles); end
      rstn = 1'b1;
   endtask

   task automatic test_basic;
      step(2'b11, 1, 2, 2'd0, 1'b0, 1'b0);
      checks++; if (count !== 5'd2) begin errors++; $display("FAIL basic_count got %0d exp 2", count); end
      checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL basic_out_valid got %b exp 11", out_valid); end
      checks++; if (out_data !== {rec(2), rec(1)}) begin errors++; $display("FAIL basic_out_data got %h exp %h", out_data[31:0], rec(1)); end
      step(2'b01, 3, 0, 2'd2, 1'b0, 1'b0);
      checks++; if (count !== 5'd1 || out_valid !== 2'b01) begin errors++; $display("FAIL basic_pushpop got count %0d valid %b exp 1 01", count, out_valid); end
      checks++; if (out_data[DW-1:0] !== rec(3)) begin errors++; $display("FAIL basic_lane0 got %h exp %h", out_data[31:0], rec(3)); end
      step(2'b00, 0, 0, 2'd1, 1'b0, 1'b0);
      checks++; if (count !== 5'd0 || out_valid !== 2'b00) begin errors++; $display("FAIL basic_empty got count %0d valid %b exp 0 00", count, out_valid); end
      exp_push += 3;
   endtask

   task automatic test_fill;
      for (int k = 0; k < 8; k++) begin
         step(2'b11, 100 + 2*k, 101 + 2*k, 2'd0, 1'b0, 1'b0);
         checks++; if (count !== 5'(2*k + 2)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", k, count, 2*k + 2); end
         checks++; if (almost_full !== (2*k + 2 >= 8)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", k, almost_full, (2*k + 2 >= 8)); end
      end
      exp_push += 16;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
      for (int j = 0; j < 3; j++) begin
         step(2'b11, 900, 901, 2'd0, 1'b0, 1'b0);
         checks++; if (count !== 5'd16 || out_data[DW-1:0] !== rec(100)) begin errors++; $display("FAIL full_blocked[%0d] got count %0d lane0 %h exp 16 %h", j, count, out_data[31:0], rec(100)); end
      end
      exp_full += 3;
      for (int k = 0; k < 8; k++) begin
         checks++; if (out_data !== {rec(101 + 2*k), rec(100 + 2*k)}) begin errors++; $display("FAIL drain_order[%0d] got %h/%h exp %h/%h", k, out_data[31:0], out_data[DW+31:DW], rec(100 + 2*k), rec(101 + 2*k)); end
         step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
      end
      checks++; if (count !== 5'd0 || almost_full !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL drain_end got count %0d af %b rdy %b exp 0 0 1", count, almost_full, in_ready); end
   endtask

   task automatic test_back_to_back;
      step(2'b11, 200, 201, 2'd0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         step(2'b11, 202 + 2*k, 203 + 2*k, 2'd2, 1'b0, 1'b0);
         checks++; if (count !== 5'd2 || out_data !== {rec(203 + 2*k), rec(202 + 2*k)}) begin errors++; $display("FAIL stream[%0d] got count %0d lane0 %h exp 2 %h", k, count, out_data[31:0], rec(202 + 2*k)); end
      end
      step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL stream_end got %0d exp 0", count); end
      exp_push += 42;
   endtask

   task automatic test_stall;
      step(2'b11, 300, 301, 2'd0, 1'b0, 1'b0);
      step(2'b11, 302, 303, 2'd0, 1'b0, 1'b0);
      step(2'b11, 304, 305, 2'd2, 1'b1, 1'b0);
      checks++; if (count !== 5'd6) begin errors++; $display("FAIL stall_count got %0d exp 6", count); end
      checks++; if (out_data !== {rec(301), rec(300)}) begin errors++; $display("FAIL stall_hold got %h exp %h", out_data[31:0], rec(300)); end
      step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
      checks++; if (count !== 5'd4 || out_data !== {rec(303), rec(302)}) begin errors++; $display("FAIL stall_release got count %0d lane0 %h exp 4 %h", count, out_data[31:0], rec(302)); end
      exp_push += 6;
   endtask

   task automatic test_stats;
`ifdef IQ_STATS_EN
      checks++; if (stat_push_cnt !== 32'(exp_push)) begin errors++; $display("FAIL stat_push got %0d exp %0d", stat_push_cnt, exp_push); end
      checks++; if (stat_full_cycles !== 32'(exp_full)) begin errors++; $display("FAIL stat_full got %0d exp %0d", stat_full_cycles, exp_full); end
`else
      checks++; if (stat_push_cnt !== 32'd0) begin errors++; $display("FAIL stat_push got %0d exp 0", stat_push_cnt); end
      checks++; if (stat_full_cycles !== 32'd0) begin errors++; $display("FAIL stat_full got %0d exp 0", stat_full_cycles); end
`endif
   endtask

   task automatic test_flush;
      step(2'b11, 400, 401, 2'd0, 1'b0, 1'b0);
      step(2'b11, 402, 403, 2'd0, 1'b0, 1'b0);
      step(2'b11, 404, 405, 2'd0, 1'b0, 1'b0);
      checks++; if (count !== 5'd10 || almost_full !== 1'b1) begin errors++; $display("FAIL preflush got count %0d af %b exp 10 1", count, almost_full); end
      step(2'b11, 500, 501, 2'd1, 1'b0, 1'b1);
      checks++; if (count !== 5'd0 || out_valid !== 2'b00 || almost_full !== 1'b0) begin errors++; $display("FAIL flush got count %0d valid %b af %b exp 0 00 0", count, out_valid, almost_full); end
      step(2'b11, 600, 601, 2'd0, 1'b0, 1'b0);
      checks++; if (count !== 5'd2 || out_data !== {rec(601), rec(600)}) begin errors++; $display("FAIL postflush got count %0d lane0 %h exp 2 %h", count, out_data[31:0], rec(600)); end
   endtask

   task automatic test_reset_mid;
      rstn = 1'b0;
      in_valid = 2'b11;
      @(posedge clk);
      #1;
      in_valid = '0;
      checks++; if (count !== 5'd0 || out_valid !== 2'b00) begin errors++; $display("FAIL midreset got count %0d valid %b exp 0 00", count, out_valid); end
      checks++; if (stat_push_cnt !== 32'd0 || stat_full_cycles !== 32'd0) begin errors++; $display("FAIL midreset_stats got %0d/%0d exp 0/0", stat_push_cnt, stat_full_cycles); end
      rstn = 1'b1;
      step(2'b11, 700, 701, 2'd0, 1'b0, 1'b0);
      checks++; if (count !== 5'd2 || out_data[DW-1:0] !== rec(700)) begin errors++; $display("FAIL postreset got count %0d lane0 %h exp 2 %h", count, out_data[31:0], rec(700)); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_fill;
      test_back_to_back;
      test_stall;
      test_stats;
      test_flush;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
